// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
// State codes are kept as fixed localparams so legacy encodings stay stable.
package seq_detect_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ARMED = ST_ARMED,
    RUN   = ST_RUN,
    DONE  = ST_DONE
  } state_t;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Configuration handshake bundle for seq_detect_ctrl.
// SEQ_DETECT_CTRL_MASK_EN adds the per-bit don't-care mask.
interface seq_detect_ctrl_if import seq_detect_pkg::*; #(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
);
  localparam int LEN_W = len_w(MAX_LEN);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
`ifdef SEQ_DETECT_CTRL_MASK_EN
  logic [MAX_LEN-1:0] cfg_mask;

  modport master (output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_mask,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_mask,
                  output cfg_ready);
`else
  modport master (output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
                  output cfg_ready);
`endif
endinterface

// File: rtl/seq_match_core.sv
// Shift history, valid-bit count and masked compare; hit is evaluated on the
// post-shift history so a match is reported on the edge that samples the last bit.
module seq_match_core import seq_detect_pkg::*; #(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic               i_seq,
  input  logic               i_overlap,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [MAX_LEN-1:0] i_mask,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_hit
);
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_cnt;
  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [LEN_W-1:0]   w_cnt_nxt;
  logic [MAX_LEN-1:0] w_len_mask;

  assign w_hist_nxt = {r_hist[MAX_LEN-2:0], i_seq};
  assign w_cnt_nxt  = (r_cnt == LEN_W'(MAX_LEN)) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_len_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_len_mask[i] = (i < 32'(i_len));
    end
  end

  assign o_hit = i_shift && (w_cnt_nxt >= i_len) &&
                 (((w_hist_nxt ^ i_pattern) & ~i_mask & w_len_mask) == '0);

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_hist <= '0;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_hist <= w_hist_nxt;
      // Non-overlapping mode restarts the count but keeps history; the count gate hides it.
      r_cnt  <= (o_hit && !i_overlap) ? '0 : w_cnt_nxt;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequencing controller for the programmable pattern detector: config handshake,
// run/abort FSM, match counter. SEQ_DETECT_CTRL_MASK_EN enables the compare mask.
module seq_detect_ctrl import seq_detect_pkg::*; #(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  seq_detect_ctrl_if.slave    cfg,
  input  logic                start,
  input  logic                abort,
  input  logic                seq_valid,
  input  logic                seq,
  output logic                detected,
  output logic [CNT_W-1:0]    match_count,
  output logic                busy,
  output logic                done
);
  localparam int LEN_W = len_w(MAX_LEN);

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [CNT_W-1:0]   r_target;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_cfg_ok;
  logic               w_start_run;
  logic               w_shift;
  logic               w_hit;
  logic [CNT_W-1:0]   w_cnt_inc;

`ifdef SEQ_DETECT_CTRL_MASK_EN
  logic [MAX_LEN-1:0] r_mask;
  assign w_mask = r_mask;
`else
  assign w_mask = '0;
`endif

  assign cfg.cfg_ready = (r_state == IDLE) || (r_state == ARMED);
  assign busy          = (r_state == RUN);
  assign done          = (r_state == DONE);

  assign w_cfg_ok    = cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_len != '0) &&
                       (cfg.cfg_len <= LEN_W'(MAX_LEN));
  // Priority: config handshake, then abort, then start.
  assign w_start_run = start && !abort && !w_cfg_ok && (r_state != IDLE);
  assign w_shift     = (r_state == RUN) && seq_valid && !abort && !start;
  assign w_cnt_inc   = (match_count == '1) ? match_count : match_count + 1'b1;

  seq_match_core #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_core (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_start_run),
    .i_shift   (w_shift),
    .i_seq     (seq),
    .i_overlap (r_overlap),
    .i_pattern (r_pattern),
    .i_mask    (w_mask),
    .i_len     (r_len),
    .o_hit     (w_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pattern   <= '0;
      r_len       <= '0;
      r_overlap   <= 1'b0;
      r_target    <= '0;
      detected    <= 1'b0;
      match_count <= '0;
`ifdef SEQ_DETECT_CTRL_MASK_EN
      r_mask      <= '0;
`endif
    end else begin
      detected <= w_hit;
      if (w_cfg_ok) begin
        r_pattern <= cfg.cfg_pattern;
        r_len     <= cfg.cfg_len;
        r_overlap <= cfg.cfg_overlap;
        r_target  <= cfg.cfg_target;
`ifdef SEQ_DETECT_CTRL_MASK_EN
        r_mask    <= cfg.cfg_mask;
`endif
        r_state   <= ARMED;
      end else if (abort && (r_state == RUN || r_state == DONE)) begin
        r_state <= ARMED;
      end else if (w_start_run) begin
        match_count <= '0;
        r_state     <= RUN;
      end else if (w_hit) begin
        match_count <= w_cnt_inc;
        if (r_target != '0 && w_cnt_inc == r_target) r_state <= DONE;
      end
    end
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial pattern-detection controller.
- Accepts a pattern configuration through a valid/ready handshake, then is armed and started.
- Runs detection on a qualified serial bit stream, counts matches and stops at a target count.
- Sits between the host control path and the serial `seq` stream; it is the configurable, sequenced successor to the fixed-pattern detector.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits; the shift history depth.
- CNT_W, 8, width of the match counter and the target count.
- LEN_W, $clog2(MAX_LEN+1), derived localparam; width of `cfg_len`.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  configuration accept; high in IDLE and ARMED.
- cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 is the first bit received, bit 0 is the last.
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- cfg_target  in  CNT_W  number of matches before DONE; 0 = unlimited.
- start  in  1  one-cycle pulse; begins or restarts a run.
- abort  in  1  one-cycle pulse; ends the run and returns to ARMED.
- seq_valid  in  1  qualifies `seq`; the history shifts only when high.
- seq  in  1  serial data bit.
- detected  out  1  one-cycle registered match pulse.
- match_count  out  CNT_W  matches in the current run; saturates at all-ones.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset values: state IDLE; `cfg_ready` 1; `detected`, `match_count`, `busy`, `done` all 0; history, valid-bit count and config registers 0.
- Reset asserted mid-run: same result on the next edge; configuration is lost.
- IDLE:
  - cfg_valid && cfg_ready with 1 <= cfg_len <= MAX_LEN: latch config, go to ARMED.
  - Illegal `cfg_len` (0 or > MAX_LEN): config ignored, stay IDLE.
  - start is ignored.
- ARMED:
  - A legal cfg handshake reloads config and stays ARMED.
  - start with no cfg handshake: clear history, hist_cnt and match_count; go to RUN.
  - cfg_valid and start in the same cycle: config wins, start is dropped.
- RUN:
  - `cfg_ready` is 0.
  - On seq_valid: history <= {history[MAX_LEN-2:0], seq}; hist_cnt increments, saturating at MAX_LEN.
  - Match condition: hist_cnt >= cfg_len and the low cfg_len bits of history equal the low cfg_len bits of the pattern. Both are evaluated on the post-shift value, in the same edge.
  - On a match: `detected` = 1 for the next cycle; match_count increments with saturation.
  - If cfg_overlap = 0, hist_cnt is cleared on a match.
  - cfg_target != 0 and the incremented count equals cfg_target: go to DONE on the same edge.
  - seq_valid low: no shift, detected 0.
  - abort: go to ARMED; match_count is held.
- DONE:
  - `done` = 1; seq is ignored.
  - start: clear count and history, go to RUN.
  - abort: go to ARMED.
- abort and start in the same cycle: abort wins.
- Latency: `detected` is asserted during the cycle immediately after the edge that samples the completing bit; there is no further pipeline stage.

Optional Feature:
- Macro: SEQ_DETECT_CTRL_MASK_EN.
- Defined:
  - Adds input port `cfg_mask` [MAX_LEN], latched together with the pattern.
  - Bits with mask = 1 are don't-care in the compare.
  - A mask of all ones within cfg_len matches on every qualifying bit once hist_cnt >= cfg_len.
- Undefined: the port is absent and all cfg_len bits are compared exactly.

Decomposition:
- Package seq_detect_pkg holds:
  - state typedef enum {IDLE, ARMED, RUN, DONE};
  - default MAX_LEN and CNT_W constants;
  - a LEN_W helper.
- Sub-module seq_match_core holds the history shift register, hist_cnt, and the masked compare. Its outputs are a combinational `hit`.
- seq_detect_ctrl owns the FSM, handshake, counter and output registers.

Test Plan:
- Pattern 4'b1011, len 4, overlap 1, target 0; stream 1,0,1,1,0,1,1 with seq_valid = 1 -> detected after bits 4 and 7; match_count = 2; busy stays 1.
- Same pattern and stream, overlap 0 -> detected after bit 4 only; match_count = 1.
- Pattern 3'b101, len 3, overlap 1, target 2; stream 1,0,1,0,1,0,1 -> second match after bit 5 gives done = 1 and busy = 0; bit 7 is ignored; match_count stays 2.
- Same run as the first scenario, with seq_valid low for 3 cycles between bits 2 and 3 -> detection timing is unchanged relative to valid bits; no spurious detected.
- cfg_len = 0 in IDLE -> state stays IDLE; start then gives busy = 0. cfg_valid and start together in ARMED -> config reloaded, busy stays 0.
- reset asserted for 1 cycle mid-RUN after 1 match -> next cycle match_count = 0, detected = 0, cfg_ready = 1; a start without a new config has no effect.
